// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request, operand and result bundle between EX and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  modport master (output start, flush, funct3, a, b, input stall, busy, done, result);
  modport slave (input start, flush, funct3, a, b, output stall, busy, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: RV32M radix-2 shift-add multiplier / restoring divider, one op at a time.
// Define MULDIV_DIV_EN to build the divider; without it divide ops complete at once with result 0.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  muldiv_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam int CW = $clog2(WIDTH + 1);
  logic [1:0]         state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               neg_q, neg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sgn_a, sgn_b, special, accept, busy;
  logic [WIDTH-1:0]   mag_a, mag_b, res_special, res_fix, mul_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step, prod, step;
  assign sgn_b = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
  assign sgn_a = sgn_b | (bus.funct3 == 3'b010);
  assign mag_a = (sgn_a && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b = (sgn_b && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign accept = (state_q == IDLE) && bus.start && !bus.flush;
  // Accumulator holds {partial product, multiplier bits not yet consumed}
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dsr_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod = neg_q ? -acc_q : acc_q;
  assign mul_res = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
  logic               nega_q;
  logic [WIDTH:0]     rem_sh, diff;
  logic [2*WIDTH-1:0] div_step;
  logic [WIDTH-1:0]   quo, rem;
  // Restoring step: {remainder, dividend->quotient} shifts left one bit per cycle
  assign rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff = rem_sh - {1'b0, dsr_q};
  assign div_step = {diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0], acc_q[WIDTH-2:0], ~diff[WIDTH]};
  assign quo = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem = nega_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign step = op_q[2] ? div_step : mul_step;
  assign res_fix = op_q[2] ? (op_q[1] ? rem : quo) : mul_res;
  assign special = bus.funct3[2] && (bus.b == '0 ||
                   (bus.a == {1'b1, {(WIDTH-1){1'b0}}} && (&bus.b) && !bus.funct3[0]));
  assign res_special = (bus.b == '0) ? (bus.funct3[1] ? bus.a : '1) : (bus.funct3[1] ? '0 : bus.a);
  always_ff @(posedge clk)
    nega_q <= reset ? 1'b0 : (accept ? (sgn_a & bus.a[WIDTH-1]) : nega_q);
`else
  assign step = mul_step;
  assign res_fix = op_q[2] ? '0 : mul_res;
  assign special = bus.funct3[2];
  assign res_special = '0;
`endif
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    dsr_d   = dsr_q;
    res_d   = res_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    if (bus.flush) state_d = IDLE;
    else if (accept) begin
      op_d    = bus.funct3;
      acc_d   = {{WIDTH{1'b0}}, mag_a};
      dsr_d   = mag_b;
      neg_d   = (sgn_a & bus.a[WIDTH-1]) ^ (sgn_b & bus.b[WIDTH-1]);
      cnt_d   = '0;
      res_d   = res_special;
      state_d = special ? DONE : CALC;
    end else if (state_q == CALC) begin
      acc_d   = step;
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : CALC;
    end else if (state_q == FIX) begin
      res_d   = res_fix;
      state_d = DONE;
    end else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      dsr_q   <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      dsr_q   <= dsr_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy = (state_q == CALC) || (state_q == FIX);
  assign bus.busy = busy;
  assign bus.stall = accept || busy;
  assign bus.done = (state_q == DONE);
  assign bus.result = (state_q == DONE) ? res_q : '0;
endmodule
